slave_port_arbiter: RTL
=======================

Name: slave_port_arbiter

Overview:
- Per-slave arbiter and transaction sequencer for the 2x2 Cross_bar; one instance per slave port.
- Accepts requests from NUM_MASTERS masters targeting this slave and grants one at a time, round-robin.
- Latches the winner's command into the slave port and holds the grant until the transaction completes: write ends on ack, read ends on resp.
- Returns ack, resp and rdata only to the granted master.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8)
- ADDR_W, 31, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 256, watchdog limit, used only with the optional feature

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- m_req_i  in  NUM_MASTERS  per-master request, already decoded to this slave
- m_addr_i  in  NUM_MASTERS*ADDR_W  per-master address, master k at bits [k*ADDR_W +: ADDR_W]
- m_cmd_i  in  NUM_MASTERS  per-master command, 1=write, 0=read
- m_wdata_i  in  NUM_MASTERS*DATA_W  per-master write data
- m_ack_o  out  NUM_MASTERS  per-master ack
- m_resp_o  out  NUM_MASTERS  per-master read response strobe
- m_rdata_o  out  DATA_W  read data, valid while the granted master's m_resp_o is high
- s_req_o  out  1  slave request
- s_addr_o  out  ADDR_W  slave address
- s_cmd_o  out  1  slave command
- s_wdata_o  out  DATA_W  slave write data
- s_ack_i  in  1  slave ack
- s_resp_i  in  1  slave read response
- s_rdata_i  in  DATA_W  slave read data
- grant_o  out  NUM_MASTERS  one-hot current grant, 0 when idle
- busy_o  out  1  high when state is not IDLE

Behaviour:
- Reset (asynchronous, active-low), also mid-transaction:
  - state=IDLE, grant_o=0, last-grant pointer=NUM_MASTERS-1 (master 0 wins the first tie).
  - s_req_o=0, s_addr_o=0, s_cmd_o=0, s_wdata_o=0.
  - m_ack_o=0, m_resp_o=0, m_rdata_o=0, busy_o=0.
  - Any in-flight transaction is dropped silently.
- State IDLE:
  - If any m_req_i bit is set, pick the first requester searching upward from pointer+1 with wrap-around.
  - At the clock edge: register grant_o, latch that master's addr/cmd/wdata into s_*_o, set s_req_o=1, go to ADDR.
  - Latency: request sampled at edge N gives s_req_o high after edge N.
  - With no request, stay in IDLE.
- State ADDR:
  - s_req_o=1; s_addr_o, s_cmd_o and s_wdata_o hold the latched values, ignoring later master input changes.
  - m_ack_o[g] = s_ack_i, combinational, granted master only; all other bits 0.
  - On s_ack_i=1 with write: clear s_req_o, set pointer=g, go to IDLE.
  - On s_ack_i=1 with read: clear s_req_o, go to WAIT_RESP.
- State WAIT_RESP:
  - m_ack_o is masked to 0, because the slave holds ack high through a read.
  - m_resp_o[g] = s_resp_i and m_rdata_o = s_rdata_i, combinational.
  - On s_resp_i=1: set pointer=g, go to IDLE.
  - If s_resp_i arrives in the same cycle as ack, complete directly from ADDR: ack and resp are both forwarded and the next state is IDLE.
- Commitment: the transaction is committed at grant. If the master drops m_req_i early, the transaction still completes.
- Back-to-back: at least one IDLE cycle separates transactions. A new grant is taken on the edge after completion and rotates fairness.
- Stray inputs: s_ack_i or s_resp_i in IDLE, and s_resp_i in ADDR for a write, are ignored.
- Fairness bound: a continuously requesting master waits at most NUM_MASTERS-1 transactions.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in ADDR and in WAIT_RESP and clears on every state change.
  - When it reaches TIMEOUT_CYCLES, the transaction is aborted: s_req_o=0 and state goes to IDLE.
  - In the abort cycle the granted master gets a one-cycle m_ack_o (ADDR abort), or m_resp_o with m_rdata_o = {DATA_W/4{4'hE}} (WAIT_RESP abort).
  - The extra output port err_o pulses for 1 cycle on abort.
  - err_o resets to 0.
- When undefined: no counter and no err_o port; the arbiter waits indefinitely.

Test Plan:
- Single write: m_req_i=2'b01, addr=31'h100, wdata=32'hA5A5A5A5, slave acks 1 cycle after s_req_o -> s_req_o high 1 cycle after req; s_addr_o=31'h100, s_wdata_o=32'hA5A5A5A5; m_ack_o=2'b01 for 1 cycle; busy_o low after.
- Single read from master 1: slave acks, then asserts resp with rdata=32'h12345678 four cycles later -> m_ack_o[1] pulses once, m_resp_o=2'b10, m_rdata_o=32'h12345678; m_ack_o stays 0 during WAIT_RESP.
- Concurrent writes: both masters assert req on the same edge after reset -> master 0 granted first, then master 1; grant_o sequence 01,00,10.
- Fairness: both masters hold req continuously for 6 writes -> grant_o alternates 01,10,01,10,01,10.
- Async reset: assert rst_n_i low during WAIT_RESP -> all outputs 0 immediately; after release a new master-1 request is granted normally.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16: slave never acks -> after 16 ADDR cycles m_ack_o[g] pulses, err_o pulses, state returns to IDLE.

Source files
------------

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter
//   Per-slave-port arbiter and transaction sequencer for the 2x2 crossbar.
//   Masters that have decoded an access to this slave raise m_req_i; one is
//   granted at a time in round-robin order. The winner's command is latched
//   onto the slave port, and the grant is held until the transaction ends.
//   A write ends on s_ack_i. A read ends on s_resp_i. The ack, resp and rdata
//   signals are returned only to the granted master.
//
//   Optional build macro: ARB_TIMEOUT_EN
//     This macro adds a watchdog that aborts a transaction stuck in ADDR or
//     WAIT_RESP after TIMEOUT_CYCLES cycles. It also adds the err_o port.
//
//   Ports
//     clk_i, rst_n_i        clock, asynchronous active-low reset
//     m_req_i/m_cmd_i       per-master request and command (1=write, 0=read)
//     m_addr_i/m_wdata_i    per-master address / write data, master k at [k*W +: W]
//     m_ack_o/m_resp_o      per-master ack / read-response strobes
//     m_rdata_o             read data returned to the granted master
//     s_req_o..s_wdata_o    latched command presented to the slave
//     s_ack_i/s_resp_i      slave handshake, s_rdata_i read data
//     grant_o               one-hot grant, 0 while idle
//     busy_o                high whenever a transaction is in flight
//     err_o                 (ARB_TIMEOUT_EN only) one-cycle pulse on watchdog abort
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no grant; arbitrate among requesters each cycle
//   ADDR      | command on slave port, waiting for s_ack_i
//   WAIT_RESP | read acked, waiting for s_resp_i (ack from slave masked)

module slave_port_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 31,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_MASTERS-1:0]        m_req_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS-1:0]        m_cmd_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]        m_ack_o,
    output logic [NUM_MASTERS-1:0]        m_resp_o,
    output logic [DATA_W-1:0]             m_rdata_o,
    output logic                          s_req_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic                          s_cmd_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    input  logic                          s_ack_i,
    input  logic                          s_resp_i,
    input  logic [DATA_W-1:0]             s_rdata_i,
    output logic [NUM_MASTERS-1:0]        grant_o,
`ifdef ARB_TIMEOUT_EN
    output logic                          err_o,
`endif
    output logic                          busy_o
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("slave_port_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR      = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [PW-1:0]            gidx_q, gidx_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic                     s_req_q, s_req_d;
    logic                     s_cmd_q, s_cmd_d;
    logic [ADDR_W-1:0]        s_addr_q, s_addr_d;
    logic [DATA_W-1:0]        s_wdata_q, s_wdata_d;
    logic                     txn_done;

    logic                     win_found;
    logic [PW-1:0]            win_idx;
    logic [NUM_MASTERS-1:0]   win_onehot;
    logic [ADDR_W-1:0]        win_addr;
    logic                     win_cmd;
    logic [DATA_W-1:0]        win_wdata;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmr_q, tmr_d;
    logic          tmo_hit;
    logic          abort;

    // Down-counter reloaded on every state change; terminal count of zero
    // marks the TIMEOUT_CYCLES-th cycle spent in the current busy state.
    assign tmo_hit = (state_q != ST_IDLE) && (tmr_q == '0);

    always_comb begin
        tmr_d = tmr_q;
        if (state_d != state_q || state_q == ST_IDLE) begin
            tmr_d = TW'(TIMEOUT_CYCLES - 1);
        end else begin
            tmr_d = tmr_q - TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr_q <= TW'(TIMEOUT_CYCLES - 1);
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign err_o = abort;
`endif

    // Round-robin search: first requester strictly above the last grant,
    // wrapping around, so the previous winner has the lowest priority.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            if (!win_found && m_req_i[PW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = PW'(cand);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        win_addr   = '0;
        win_cmd    = 1'b0;
        win_wdata  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (win_idx == PW'(k)) begin
                win_onehot[k] = 1'b1;
                win_addr      = m_addr_i[k*ADDR_W +: ADDR_W];
                win_cmd       = m_cmd_i[k];
                win_wdata     = m_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        s_req_d   = s_req_q;
        s_cmd_d   = s_cmd_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        m_ack_o   = '0;
        m_resp_o  = '0;
        m_rdata_o = '0;
        txn_done  = 1'b0;
`ifdef ARB_TIMEOUT_EN
        abort     = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d   = ST_ADDR;
                    grant_d   = win_onehot;
                    gidx_d    = win_idx;
                    s_req_d   = 1'b1;
                    s_addr_d  = win_addr;
                    s_cmd_d   = win_cmd;
                    s_wdata_d = win_wdata;
                end
            end

            ST_ADDR: begin
                m_ack_o[gidx_q] = s_ack_i;
                if (s_ack_i) begin
                    if (s_cmd_q) begin
                        txn_done = 1'b1;
                    end else if (s_resp_i) begin
                        // Read completing in the ack cycle: forward both strobes.
                        m_resp_o[gidx_q] = 1'b1;
                        m_rdata_o        = s_rdata_i;
                        txn_done         = 1'b1;
                    end else begin
                        state_d = ST_WAIT_RESP;
                        s_req_d = 1'b0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    m_ack_o[gidx_q] = 1'b1;
                    abort           = 1'b1;
                    txn_done        = 1'b1;
                end
`endif
            end

            ST_WAIT_RESP: begin
                // The slave keeps ack high through a read, so ack is not forwarded here.
                m_resp_o[gidx_q] = s_resp_i;
                m_rdata_o        = s_rdata_i;
                if (s_resp_i) begin
                    txn_done = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    m_resp_o[gidx_q] = 1'b1;
                    m_rdata_o        = {DATA_W/4{4'hE}};
                    abort            = 1'b1;
                    txn_done         = 1'b1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (txn_done) begin
            state_d = ST_IDLE;
            grant_d = '0;
            s_req_d = 1'b0;
            ptr_d   = gidx_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= PW'(NUM_MASTERS - 1);
            s_req_q   <= 1'b0;
            s_cmd_q   <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            s_req_q   <= s_req_d;
            s_cmd_q   <= s_cmd_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
        end
    end

    assign grant_o   = grant_q;
    assign s_req_o   = s_req_q;
    assign s_addr_o  = s_addr_q;
    assign s_cmd_o   = s_cmd_q;
    assign s_wdata_o = s_wdata_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule
